// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the control unit.
// It holds the opcode constants, the bit positions of the fixed 16-bit
// instruction fields, and the state encoding of the fetch FSM.
package cpu_pkg;

  // Opcode map in instr[15:12]. 1101 and 1110 are reserved.
  // The fetch stage issues reserved opcodes like any other instruction.
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_EQ   = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Instruction field positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 8;
  localparam int SRCA_MSB = 7;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_MSB = 3;
  localparam int SRCB_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_REQ    = 2'd1,
    FS_ISSUE  = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage placed in front of the control unit.
// It keeps the PC, fetches 16-bit words over a req/ack handshake and
// latches each word into the IR. Fields go out on a valid/ready handshake.
// JMP and HALT are resolved here and are never issued downstream.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   run                     start fetching; sampled only in IDLE
//   imem_req/imem_addr      fetch request; the address is the PC
//   imem_data/imem_ack      returned instruction word and its ack
//   opcode/dst/src_a/src_b  IR fields
//   instr_valid/instr_ready issue handshake
//   pc, halted              program counter; set once HALT is reached
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | wait for run
// REQ      | request outstanding at pc, wait for imem_ack
// ISSUE    | IR holds a word: resolve JMP/HALT or issue it
// HALTED   | terminal state, left only through reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_ack,
  output logic [3:0]        opcode,
  output logic [3:0]        dst,
  output logic [3:0]        src_a,
  output logic [3:0]        src_b,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              halted_q, halted_d;

  logic              is_jmp;
  logic              is_halt;

  assign is_jmp  = (ir_q[OPC_MSB:OPC_LSB] == OP_JMP);
  assign is_halt = (ir_q[OPC_MSB:OPC_LSB] == OP_HALT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      FS_IDLE: begin
        if (run) state_d = FS_REQ;
      end
      FS_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
          state_d = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (is_jmp) begin
          // The target replaces the already incremented PC.
          pc_d    = ir_q[ADDR_W-1:0];
          state_d = FS_REQ;
        end else if (is_halt) begin
          halted_d = 1'b1;
          state_d  = FS_HALTED;
        end else if (instr_ready) begin
          state_d = FS_REQ;
        end
      end
      FS_HALTED: begin
        state_d = FS_HALTED;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Outputs are decoded from registered state and the IR only. They have no
  // path from imem_ack or instr_ready.
  assign imem_req    = (state_q == FS_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign instr_valid = (state_q == FS_ISSUE) && !is_jmp && !is_halt;
  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign dst         = ir_q[DST_MSB:DST_LSB];
  assign src_a       = ir_q[SRCA_MSB:SRCA_LSB];
  assign src_b       = ir_q[SRCB_MSB:SRCB_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic [3:0]  opcode, dst, src_a, src_b;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        halted;

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .opcode(opcode), .dst(dst), .src_a(src_a), .src_b(src_b),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fields();
    return {opcode, dst, src_a, src_b};
  endfunction

  // ---------------- random-mode memory / consumer model -----------------
  logic [15:0] mem [256];
  logic [7:0]  model_fetch [$];
  logic [15:0] model_issue [$];
  logic        model_halt;
  bit          auto_mode = 0;
  bit          in_req;
  int          wait_cnt;
  int          fidx, iidx;
  bit          prev_hold;
  logic [15:0] prev_fields;

  // Architectural walk of the program: fetch, advance, jump or halt.
  task automatic build_model();
    logic [7:0]  p;
    logic [15:0] w;
    model_fetch.delete();
    model_issue.delete();
    model_halt = 0;
    p = 8'h00;
    while (model_fetch.size() < 4000 && !model_halt) begin
      w = mem[p];
      model_fetch.push_back(p);
      p = p + 8'd1;
      if (w[15:12] == 4'hC) p = w[7:0];
      else if (w[15:12] == 4'hF) model_halt = 1;
      else model_issue.push_back(w);
    end
  endtask

  task automatic auto_drive();
    if (prev_hold) begin
      check("hold_valid", instr_valid, 1);
      check("hold_fields", fields(), prev_fields);
    end
    if (imem_req) begin
      if (!in_req) begin
        in_req   = 1;
        wait_cnt = $urandom_range(0, 3);
      end
      if (wait_cnt == 0) begin
        imem_ack  = 1;
        imem_data = mem[imem_addr];
        in_req    = 0;
        if (fidx < model_fetch.size()) check("fetch_addr", imem_addr, model_fetch[fidx]);
        else check("extra_fetch", fidx, model_fetch.size());
        fidx++;
      end else begin
        imem_ack  = 0;
        imem_data = 16'($urandom);
        wait_cnt--;
      end
    end else begin
      // Spurious acks outside REQ must be ignored.
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
    end
    instr_ready = 1'($urandom_range(0, 1));
    run         = 1'($urandom_range(0, 1));
    if (instr_valid && instr_ready) begin
      if (iidx < model_issue.size()) check("issue_fields", fields(), model_issue[iidx]);
      else check("extra_issue", iidx, model_issue.size());
      iidx++;
    end
    prev_hold   = instr_valid && !instr_ready;
    prev_fields = fields();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_mode) auto_drive();
  endtask

  task automatic do_reset();
    rst_n = 0; run = 0; imem_ack = 0; imem_data = '0; instr_ready = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // Ack the outstanding request immediately with w, then let ISSUE pass.
  task automatic fetch_one(input logic [15:0] w);
    imem_ack = 1; imem_data = w; instr_ready = 1;
    step();
    imem_ack = 0;
    step();
  endtask

  typedef struct {
    logic [15:0] word;
    logic        exp_valid;
    logic        exp_halt;
    logic [7:0]  exp_next;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{16'h2123, 1'b1, 1'b0, 8'h01};
    tbl[1] = '{16'h0000, 1'b1, 1'b0, 8'h01};
    tbl[2] = '{16'hD5A7, 1'b1, 1'b0, 8'h01};
    tbl[3] = '{16'hE0F1, 1'b1, 1'b0, 8'h01};
    tbl[4] = '{16'hBFFF, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{16'hC040, 1'b0, 1'b0, 8'h40};
    tbl[6] = '{16'hC3FF, 1'b0, 1'b0, 8'hFF};
    tbl[7] = '{16'hF000, 1'b0, 1'b1, 8'h00};
    tbl[8] = '{16'h7ABC, 1'b1, 1'b0, 8'h01};

    // Reset state, and IDLE holds while run=0.
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_fields", fields(), 16'h0000);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 0);
    step(); step();
    check("idle_no_req", imem_req, 0);

    // Table: one word at addr 0, immediate ack, ready high.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      run = 1;
      step();
      run = 0;
      check("tbl_req", imem_req, 1);
      check("tbl_addr0", imem_addr, 8'h00);
      imem_ack = 1; imem_data = tbl[i].word; instr_ready = 1;
      step();
      imem_ack = 0;
      check("tbl_valid", instr_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check("tbl_fields", fields(), tbl[i].word);
      check("tbl_issue_noreq", imem_req, 0);
      step();
      if (tbl[i].exp_halt) begin
        check("tbl_halted", halted, 1);
        check("tbl_halt_noreq", imem_req, 0);
      end else begin
        check("tbl_next_req", imem_req, 1);
        check("tbl_next_addr", imem_addr, tbl[i].exp_next);
      end
    end

    // Ack delayed 3 cycles, then ready held low for 5 cycles.
    do_reset();
    run = 1;
    step();
    run = 0;
    imem_data = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 8'h00);
      check("wait_ir", fields(), 16'h0000);
      step();
    end
    check("wait_req4", imem_req, 1);
    check("wait_addr4", imem_addr, 8'h00);
    imem_ack = 1; imem_data = 16'h2123; instr_ready = 0;
    step();
    imem_ack = 0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", instr_valid, 1);
      check("stall_fields", fields(), 16'h2123);
      check("stall_noreq", imem_req, 0);
      step();
    end
    check("stall_valid_end", instr_valid, 1);
    instr_ready = 1;
    step();
    check("post_hs_valid", instr_valid, 0);
    check("post_hs_req", imem_req, 1);
    check("post_hs_addr", imem_addr, 8'h01);

    // JMP at address 3.
    do_reset();
    run = 1;
    step();
    run = 0;
    fetch_one(16'h0000); fetch_one(16'h1000); fetch_one(16'h2000);
    check("jmp3_addr", imem_addr, 8'h03);
    imem_ack = 1; imem_data = 16'hC040;
    step();
    imem_ack = 0;
    check("jmp3_novalid", instr_valid, 0);
    step();
    check("jmp3_target", imem_addr, 8'h40);
    check("jmp3_req", imem_req, 1);

    // PC wrap from 0xFF.
    do_reset();
    run = 1;
    step();
    run = 0;
    fetch_one(16'hC0FF);
    check("wrap_at_ff", imem_addr, 8'hFF);
    fetch_one(16'h1234);
    check("wrap_addr", imem_addr, 8'h00);
    check("wrap_pc", pc, 8'h00);

    // HALT is terminal until reset.
    do_reset();
    run = 1;
    step();
    fetch_one(16'hF000);
    for (int k = 0; k < 20; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      check("halt_state", {halted, imem_req, instr_valid}, 3'b100);
      step();
    end
    imem_ack = 0;
    rst_n = 0;
    step();
    rst_n = 1; run = 0;
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_halted", halted, 0);
    check("halt_rst_req", imem_req, 0);
    step();
    check("halt_rst_idle", imem_req, 0);

    // Reset while ISSUE holds an unaccepted instruction.
    do_reset();
    run = 1;
    step();
    imem_ack = 1; imem_data = 16'h2123; instr_ready = 0;
    step();
    imem_ack = 0;
    check("mid_valid_pre", instr_valid, 1);
    rst_n = 0;
    step();
    rst_n = 1; run = 0;
    check("mid_valid", instr_valid, 0);
    check("mid_opcode", opcode, 4'h0);
    check("mid_pc", pc, 8'h00);
    check("mid_req", imem_req, 0);

    // Reset while a request is outstanding.
    run = 1;
    step();
    run = 0;
    check("mreq_pre", imem_req, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    check("mreq_req", imem_req, 0);
    check("mreq_pc", pc, 8'h00);

    // Random programs against the architectural model.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      build_model();
      do_reset();
      in_req = 0; prev_hold = 0; fidx = 0; iidx = 0;
      run = 1;
      step();
      auto_mode = 1;
      for (int c = 0; c < 3000 && !halted; c++) step();
      auto_mode = 0;
      if (halted) begin
        check("rnd_model_halt", model_halt, 1);
        check("rnd_fetch_count", fidx, model_fetch.size());
        check("rnd_issue_count", iidx, model_issue.size());
      end else begin
        check("rnd_fetch_prefix", (fidx <= model_fetch.size()), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. It holds the program counter, fetches 16-bit instructions from instruction memory over a request/acknowledge handshake, and latches them into an instruction register. It issues opcode and operand fields to the control unit and datapath with a valid/ready handshake. JMP and HALT are resolved locally and never reach the control unit.

## Interface
- ADDR_W, 8, instruction memory address / PC width
- DATA_W, 16, instruction width; fixed layout below, only 16 supported
- RESET_PC, 0, PC value after reset
- clk  input  1  clock, all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- run  input  1  leave IDLE and begin fetching
- imem_req  output  1  fetch request, held until acknowledged
- imem_addr  output  ADDR_W  fetch address, equal to pc
- imem_data  input  DATA_W  instruction word, valid when imem_ack=1
- imem_ack  input  1  memory completes request this cycle
- opcode  output  4  instr[15:12], to control unit
- dst  output  4  instr[11:8]
- src_a  output  4  instr[7:4]
- src_b  output  4  instr[3:0]
- instr_valid  output  1  fields valid
- instr_ready  input  1  downstream accepts
- pc  output  ADDR_W  current program counter
- halted  output  1  HALT executed

## Operation
- States: IDLE, REQ, ISSUE, HALTED.
- IDLE: imem_req=0. When run=1, go to REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack=1: capture imem_data into IR, pc <= pc+1 (modulo 2^ADDR_W, so 0xFF wraps to 0x00), go to ISSUE. Otherwise stay. imem_ack outside REQ is ignored.
- ISSUE, decode IR[15:12]:
  - 4'b1100 JMP: pc <= IR[ADDR_W-1:0], instr_valid stays 0, go to REQ.
  - 4'b1111 HALT: halted <= 1, go to HALTED. instr_valid stays 0.
  - All other opcodes, including 0000 NOP and reserved 1101/1110: instr_valid=1 with fields from IR. Fields are held stable until instr_valid && instr_ready; on that edge go to REQ.
- HALTED: terminal. Outputs are frozen, imem_req=0, instr_valid=0. Only rst_n exits this state.
- run is sampled only in IDLE. Deasserting run after leaving IDLE has no effect.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, IR=0, so opcode/dst/src_a/src_b=0. imem_req=0, instr_valid=0, halted=0.
- Reset mid-operation (REQ with an outstanding request, or ISSUE with valid not yet accepted): takes effect at the next edge. The request is dropped with no ack required, the pending instruction is discarded, and all reset values apply.
- All outputs are registered or decode directly from state/IR. No combinational path from imem_ack or instr_ready to any output.
- Best case (ack in the first REQ cycle, ready already high): run edge → REQ (cycle 1, req=1, ack) → ISSUE (cycle 2, valid=1, accepted) → REQ (cycle 3). Throughput is one instruction per 2 cycles.
- Each additional ack wait cycle adds one cycle. Each cycle with instr_ready=0 adds one cycle.
- JMP costs 2 cycles (REQ+ISSUE) and produces no issued instruction. The next fetch address is the jump target.
- instr_valid never deasserts without a handshake, except on reset.

## Structure
- Shared package cpu_pkg: opcode localparams (OP_NOP=4'b0000, OP_MOV=4'b0001 … OP_EQ=4'b1011, OP_JMP=4'b1100, OP_HALT=4'b1111), instruction field bit positions, and the fetch state encoding. The control unit uses the same opcode constants.
- Single module, no sub-module. The PC and IR are plain registers inside fetch_unit.

## Test plan
- Reset then run=1, memory acks immediately with 0x2123 at addr 0, ready=1 → cycle 2: opcode=0010, dst=1, src_a=2, src_b=3, valid=1; cycle 3: imem_addr=0x01.
- Ack delayed 3 cycles → imem_req held with imem_addr constant for 4 cycles; IR updates only on the ack cycle.
- instr_ready=0 for 5 cycles while valid=1 → fields and valid stable for all 5 cycles; no new imem_req until the handshake.
- Word 0xC040 at addr 3 → no valid pulse; next imem_addr=0x40. Separately, pc at 0xFF with a normal instruction → next fetch addr 0x00.
- Word 0xF000 → halted=1, imem_req stays 0 for 20 cycles despite run=1. Then rst_n=0 for one edge → pc=RESET_PC, halted=0, state IDLE.
- rst_n=0 while in ISSUE with valid=1 and ready=0 → next edge: valid=0, opcode=0, pc=RESET_PC, imem_req=0.
